// File: rtl/uart_receive_if.sv
// rtl/uart_receive_if.sv - serial line in, received byte and status strobes out
interface uart_receive_if;
  logic       rx_wire_in;
  logic [7:0] data_byte_out;
  logic       new_data_out;
  logic       framing_error_out;
  logic       busy_out;

  modport master (
    output rx_wire_in,
    input  data_byte_out, new_data_out, framing_error_out, busy_out
  );

  modport slave (
    input  rx_wire_in,
    output data_byte_out, new_data_out, framing_error_out, busy_out
  );
endinterface

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1 UART receiver: mid-bit sampling, one-cycle byte and
// framing-error strobes
module uart_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 460800
) (
  input  logic          clk_in,
  input  logic          rst_in,
  uart_receive_if.slave rx_if
);
  localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD     = BAUD_BIT_PERIOD / 2;
  localparam int CW              = $clog2(BAUD_BIT_PERIOD) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_BIT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          new_q, new_d;
  logic          fe_q, fe_d;
  logic          meta_q, sync_q;
  logic [1:0]    settle_q;
  logic          armed_q;

  // The synchronizer's reset value of 1 is not a real observation of the line,
  // so a start is only armed once rx_sync has been seen high after it settles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      new_q     <= 1'b0;
      fe_q      <= 1'b0;
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      settle_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      new_q     <= new_d;
      fe_q      <= fe_d;
      meta_q    <= rx_if.rx_wire_in;
      sync_q    <= meta_q;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_q | (settle_q[1] & sync_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!sync_q && armed_q) state_d = START;
      START:     if (cnt_q == HALF_LAST) state_d = sync_q ? IDLE : DATA;
      DATA:      if (cnt_q == BIT_LAST && bit_cnt_q == 3'd7) state_d = STOP;
      STOP:      if (cnt_q == BIT_LAST) state_d = sync_q ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (sync_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    new_d     = 1'b0;
    fe_d      = 1'b0;
    if (state_d != state_q || state_q == IDLE || state_q == WAIT_HIGH) begin
      cnt_d = '0;
    end
    if (state_q == START && state_d == DATA) begin
      bit_cnt_d = '0;
    end
    if (state_q == DATA && cnt_q == BIT_LAST) begin
      cnt_d     = '0;
      shift_d   = {sync_q, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (state_q == STOP && cnt_q == BIT_LAST) begin
      new_d = sync_q;
      fe_d  = ~sync_q;
      if (sync_q) data_d = shift_q;
    end
  end

  assign rx_if.data_byte_out     = data_q;
  assign rx_if.new_data_out      = new_q;
  assign rx_if.framing_error_out = fe_q;
  assign rx_if.busy_out          = (state_q != IDLE);
endmodule
